cam_yuv_capture: RTL and testbench
==================================

Name: cam_yuv_capture

Overview:
Parametrised successor to the fixed camera-to-framebuffer path: captures OV7670-style YUV422 bytes, deinterleaves them into per-pixel Y/Cb/Cr and applies a programmable green-key test. It decimates by 2^SCALE_LOG2 and drives framebuffer write address/data/enable plus frame status. It sits between the camera GPIO pins and the framebuffer write port, in the PCLK domain.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
SCALE_LOG2, 0, decimation exponent (0..2); output frame is (H_ACTIVE>>S) x (V_ACTIVE>>S)
ADDR_W, 19, write-address width; must hold (H_ACTIVE*V_ACTIVE)>>(2S)
DATA_W, 8, camera byte and output pixel width

Ports:
PCLK  in  1  capture clock (the only clock)
reset  in  1  asynchronous, active-high
D  in  DATA_W  camera data byte
VSYNC  in  1  high = vertical blanking
HREF  in  1  high = valid byte on D
enable  in  1  arm capture
single_shot  in  1  1 = stop after one good frame
mode  in  2  0 luma, 1 green mask, 2 luma with green forced to 0, 3 reserved (= 0)
y_min  in  DATA_W  green test: Y > y_min
cb_max  in  DATA_W  green test: Cb < cb_max
cr_max  in  DATA_W  green test: Cr < cr_max
wr_en  out  1  framebuffer write strobe
wr_addr  out  ADDR_W  framebuffer address
wr_data  out  DATA_W  pixel value
verde  out  1  green flag of the current wr_data pixel
frame_done  out  1  one-cycle pulse, good frame completed
frame_err  out  1  one-cycle pulse, malformed frame completed
busy  out  1  high in ACTIVE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, byte phase 0.
- FSM: IDLE -> (enable && VSYNC falling edge) -> ACTIVE; ACTIVE -> (VSYNC rising) -> IDLE, or HOLD if single_shot and frame good; HOLD -> (!enable) -> IDLE. A frame already in progress when enable rises is ignored; capture starts only at the next VSYNC fall.
- Byte order per group: Y0, Cb, Y1, Cr, with phase counter 0..3 advancing on HREF high. After the Cr byte, pixel0 (Y0,Cb,Cr) is emitted the next cycle and pixel1 (Y1,Cb,Cr) the cycle after. Emission happens whether or not HREF is still high.
- Latency: wr_en for pixel0 is 1 cycle after Cr is sampled. Sustained rate is 2 pixels per 4 bytes.
- Green test: verde = (Y > y_min) && (Cb < cb_max) && (Cr < cr_max), unsigned, registered with wr_data.
- wr_data by mode: 0 = Y; 1 = all-ones if verde else 0; 2 = 0 if verde else Y.
- Pixel x counts 0..H_ACTIVE-1 and line y counts 0..V_ACTIVE-1. y increments on HREF falling edge, but only if the line emitted at least one pixel.
- Decimation: write only when the low S bits of x and y are both 0. wr_addr is an incrementing counter that starts at 0 each frame and increments after each write. No multiplier.
- HREF falling with phase != 0: the partial group is discarded, phase resets to 0, and the frame is marked bad.
- Overflow: pixels with x >= H_ACTIVE or lines with y >= V_ACTIVE are dropped (no wr_en) and the frame is marked bad.
- End of frame: on VSYNC rising in ACTIVE, pulse frame_done if y == V_ACTIVE and the frame is not bad; otherwise pulse frame_err. Then clear the bad flag.
- Short lines (x < H_ACTIVE at HREF fall) mark the frame bad. wr_addr is not padded.
- enable low in ACTIVE: finish the current frame, then go to IDLE.
- Reset mid-frame: immediate return to IDLE; no pulses; a pending pixel1 is lost.
- Simultaneous HREF fall and Cr byte: the Cr byte is still captured and both pixels are emitted.

Decomposition:
- Shared package cam_pkg holds:
  - the mode encoding constants (MODE_LUMA, MODE_MASK, MODE_KEYOUT);
  - the FSM state typedef (IDLE, ACTIVE, HOLD);
  - byte-phase constants.
- Sub-module yuv_green_key (combinational green test plus mode mux, registered once) is reused by future detectors.

Test Plan:
- Reset then HREF bytes with no VSYNC fall -> wr_en never asserted, busy=0.
- H=4, V=2, S=0, mode 0, two lines of 8 bytes each (bytes 10,128,20,128, 30,128,40,128) -> Y values 10,20,30,40 written at addresses 0..3 then 4..7; wr_en first high 1 cycle after the first Cr; frame_done pulses at VSYNC rise.
- mode 1, y_min=16, cb_max=100, cr_max=100, group (50,90,10,90) -> pixel0 wr_data=0xFF, verde=1; pixel1 wr_data=0x00, verde=0.
- H=8, V=4, S=1, full frame -> exactly 8 writes, addresses 0..7, all taken from even x and even y.
- Line of 10 pixels with H=8 -> 8 writes only; frame_err at VSYNC rise, no frame_done.
- single_shot=1, two frames -> first frame written, state HOLD, no writes in the second frame; enable low then high re-arms capture at the next VSYNC fall.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared encodings for the camera capture path: output modes, FSM states, byte phases.
package cam_pkg;
    localparam logic [1:0] MODE_LUMA   = 2'd0;
    localparam logic [1:0] MODE_MASK   = 2'd1;
    localparam logic [1:0] MODE_KEYOUT = 2'd2;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACTIVE = 2'd1;
    localparam state_t HOLD   = 2'd2;

    localparam logic [1:0] PH_Y0 = 2'd0;
    localparam logic [1:0] PH_CB = 2'd1;
    localparam logic [1:0] PH_Y1 = 2'd2;
    localparam logic [1:0] PH_CR = 2'd3;
endpackage

// File: rtl/yuv_green_key.sv
// Unsigned green-key test plus output-mode select, registered once when load is high.
module yuv_green_key
    import cam_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              PCLK,
    input  logic              reset,
    input  logic              load,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] cb,
    input  logic [DATA_W-1:0] cr,
    input  logic [DATA_W-1:0] y_min,
    input  logic [DATA_W-1:0] cb_max,
    input  logic [DATA_W-1:0] cr_max,
    output logic [DATA_W-1:0] pix,
    output logic              verde
);
    logic              green_c;
    logic [DATA_W-1:0] pix_c;

    always_comb begin
        green_c = (y > y_min) && (cb < cb_max) && (cr < cr_max);
        pix_c   = '0;
        case (mode)
            MODE_LUMA:   pix_c = y;
            MODE_MASK:   pix_c = green_c ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            MODE_KEYOUT: pix_c = green_c ? {DATA_W{1'b0}} : y;
            default:     pix_c = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            pix   <= '0;
            verde <= 1'b0;
        end else if (load) begin
            pix   <= pix_c;
            verde <= green_c;
        end
    end
endmodule

// File: rtl/cam_yuv_capture.sv
// YUV422 camera capture: deinterleave, green key, 2^S decimation, framebuffer writes and frame status.
module cam_yuv_capture
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              PCLK,
    input  logic              reset,
    input  logic [DATA_W-1:0] D,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic              enable,
    input  logic              single_shot,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] y_min,
    input  logic [DATA_W-1:0] cb_max,
    input  logic [DATA_W-1:0] cr_max,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              verde,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);
    localparam int unsigned    X_W    = $clog2(H_ACTIVE + 1);
    localparam int unsigned    Y_W    = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0] H_LIM  = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] V_LIM  = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] X_MASK = X_W'((32'd1 << SCALE_LOG2) - 32'd1);
    localparam logic [Y_W-1:0] Y_MASK = Y_W'((32'd1 << SCALE_LOG2) - 32'd1);

    state_t            state, state_nx;
    logic              vsync_q, href_q;
    logic [1:0]        phase;
    logic [DATA_W-1:0] y0_r, cb_r, y1_r, cr_r;
    logic              emit0, emit1;
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              bad, px_seen, eol_pend;

    logic              vsync_fall_c, vsync_rise_c, href_fall_c;
    logic              start_c, eof_c, good_c, emit_c, in_range_c, write_c, eol_c;
    logic [DATA_W-1:0] pix_y_c;

    always_comb begin
        vsync_fall_c = vsync_q & ~VSYNC;
        vsync_rise_c = ~vsync_q & VSYNC;
        href_fall_c  = (state == ACTIVE) & href_q & ~HREF;
        start_c      = (state == IDLE) & enable & vsync_fall_c;
        eof_c        = (state == ACTIVE) & vsync_rise_c;
        good_c       = (y_cnt == V_LIM) & ~bad;
        emit_c       = emit0 | emit1;
        pix_y_c      = emit0 ? y0_r : y1_r;
        in_range_c   = (x_cnt < H_LIM) && (y_cnt < V_LIM);
        write_c      = emit_c && in_range_c && ((x_cnt & X_MASK) == '0) && ((y_cnt & Y_MASK) == '0);
        // Line end waits for the last group's two pixels so they keep the old line number.
        eol_c        = (eol_pend | href_fall_c) & ~emit_c;
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable && vsync_fall_c) state_nx = ACTIVE;
            ACTIVE:  if (vsync_rise_c) state_nx = (single_shot && good_c) ? HOLD : IDLE;
            HOLD:    if (!enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            phase      <= PH_Y0;
            y0_r       <= '0;
            cb_r       <= '0;
            y1_r       <= '0;
            cr_r       <= '0;
            emit0      <= 1'b0;
            emit1      <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            addr_cnt   <= '0;
            bad        <= 1'b0;
            px_seen    <= 1'b0;
            eol_pend   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            vsync_q    <= VSYNC;
            href_q     <= HREF;
            emit0      <= 1'b0;
            emit1      <= emit0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            wr_en      <= write_c;
            busy       <= (state_nx == ACTIVE);

            if (write_c) begin
                wr_addr  <= addr_cnt;
                addr_cnt <= addr_cnt + 1'b1;
            end

            if (emit_c) begin
                px_seen <= 1'b1;
                if (x_cnt != H_LIM) x_cnt <= x_cnt + 1'b1;
                if (!in_range_c) bad <= 1'b1;
            end

            if (state == ACTIVE && HREF) begin
                phase <= phase + 1'b1;
                case (phase)
                    PH_Y0: y0_r <= D;
                    PH_CB: cb_r <= D;
                    PH_Y1: y1_r <= D;
                    PH_CR: begin
                        cr_r  <= D;
                        emit0 <= 1'b1;
                    end
                endcase
            end

            if (href_fall_c) begin
                eol_pend <= 1'b1;
                if (phase != PH_Y0) begin
                    phase <= PH_Y0;
                    bad   <= 1'b1;
                end
            end

            if (eol_c) begin
                eol_pend <= 1'b0;
                px_seen  <= 1'b0;
                x_cnt    <= '0;
                if (px_seen) begin
                    if (y_cnt != V_LIM) y_cnt <= y_cnt + 1'b1;
                    if (x_cnt < H_LIM)  bad   <= 1'b1;
                end
            end

            if (eof_c) begin
                frame_done <= good_c;
                frame_err  <= ~good_c;
                bad        <= 1'b0;
            end

            if (start_c) begin
                phase    <= PH_Y0;
                emit0    <= 1'b0;
                emit1    <= 1'b0;
                x_cnt    <= '0;
                y_cnt    <= '0;
                addr_cnt <= '0;
                bad      <= 1'b0;
                px_seen  <= 1'b0;
                eol_pend <= 1'b0;
            end
        end
    end

    yuv_green_key #(.DATA_W(DATA_W)) u_key (
        .PCLK   (PCLK),
        .reset  (reset),
        .load   (write_c),
        .mode   (mode),
        .y      (pix_y_c),
        .cb     (cb_r),
        .cr     (cr_r),
        .y_min  (y_min),
        .cb_max (cb_max),
        .cr_max (cr_max),
        .pix    (wr_data),
        .verde  (verde)
    );
endmodule

// File: tb/tb_cam_yuv_capture.sv
// Scoreboard bench: two capture instances (4x2 S=0, 8x4 S=1) share the camera bus.
module tb_cam_yuv_capture;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    typedef struct {
        bit is_stat;
        bit done;
        int addr;
        int data;
        bit verde;
        int cyc;
    } exp_t;

    logic          PCLK = 1'b0;
    logic          reset, VSYNC, HREF, enable, single_shot;
    logic [DW-1:0] D, y_min, cb_max, cr_max;
    logic [1:0]    mode;

    logic          wr_en_a, verde_a, done_a, err_a, busy_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] data_a;
    logic          wr_en_b, verde_b, done_b, err_b, busy_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   fbytes[$];

    // Reference model state per instance: 0 idle, 1 capturing, 2 holding.
    int hp[2] = '{4, 8};
    int vp[2] = '{2, 4};
    int sp[2] = '{0, 1};
    int m_state[2], mx[2], my[2], maddr[2];
    bit mbad[2], mpix[2];

    cam_yuv_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .SCALE_LOG2(0), .ADDR_W(AW), .DATA_W(DW)) u_dut_a (
        .PCLK(PCLK), .reset(reset), .D(D), .VSYNC(VSYNC), .HREF(HREF), .enable(enable),
        .single_shot(single_shot), .mode(mode), .y_min(y_min), .cb_max(cb_max), .cr_max(cr_max),
        .wr_en(wr_en_a), .wr_addr(addr_a), .wr_data(data_a), .verde(verde_a),
        .frame_done(done_a), .frame_err(err_a), .busy(busy_a)
    );

    cam_yuv_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .SCALE_LOG2(1), .ADDR_W(AW), .DATA_W(DW)) u_dut_b (
        .PCLK(PCLK), .reset(reset), .D(D), .VSYNC(VSYNC), .HREF(HREF), .enable(enable),
        .single_shot(single_shot), .mode(mode), .y_min(y_min), .cb_max(cb_max), .cr_max(cr_max),
        .wr_en(wr_en_b), .wr_addr(addr_b), .wr_data(data_b), .verde(verde_b),
        .frame_done(done_b), .frame_err(err_b), .busy(busy_b)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic check_out(input int d, input bit is_stat, input bit done, input bit err,
                             input int addr, input int data, input bit verde);
        exp_t e;
        bit   bad;
        checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL dut%0d_unexpected: cycle %0d stat=%0d done=%0d addr=%0d data=%0d, nothing expected",
                     d, cyc, is_stat, done, addr, data);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.is_stat != is_stat || e.cyc != cyc) bad = 1'b1;
        else if (is_stat) bad = (e.done != done) || (err == done);
        else bad = (e.addr != addr) || (e.data != data) || (e.verde != verde);
        if (bad) begin
            errors++;
            $display("FAIL dut%0d_output: got stat=%0d done=%0d err=%0d addr=%0d data=%0d verde=%0d cyc=%0d, expected stat=%0d done=%0d addr=%0d data=%0d verde=%0d cyc=%0d",
                     d, is_stat, done, err, addr, data, verde, cyc,
                     e.is_stat, e.done, e.addr, e.data, e.verde, e.cyc);
        end
    endtask

    // Monitor: every write or status pulse must match the head of that instance's queue.
    always @(negedge PCLK) begin
        if (!reset) begin
            if (wr_en_a) check_out(0, 1'b0, 1'b0, 1'b0, int'(addr_a), int'(data_a), verde_a);
            if (done_a || err_a) check_out(0, 1'b1, done_a, err_a, 0, 0, 1'b0);
            if (wr_en_b) check_out(1, 1'b0, 1'b0, 1'b0, int'(addr_b), int'(data_b), verde_b);
            if (done_b || err_b) check_out(1, 1'b1, done_b, err_b, 0, 0, 1'b0);
        end
    end

    task automatic model_pixel(input int d, input int y, input int cb, input int cr, input int ecyc);
        exp_t e;
        bit   g;
        int   data;
        int   scale;
        if (m_state[d] != 1) return;
        mpix[d] = 1'b1;
        scale = 1 << sp[d];
        if (mx[d] < hp[d] && my[d] < vp[d]) begin
            if (mx[d] % scale == 0 && my[d] % scale == 0) begin
                g = (y > int'(y_min)) && (cb < int'(cb_max)) && (cr < int'(cr_max));
                case (mode)
                    2'd0:    data = y;
                    2'd1:    data = g ? 255 : 0;
                    2'd2:    data = g ? 0 : y;
                    default: data = 0;
                endcase
                e.is_stat = 1'b0;
                e.done    = 1'b0;
                e.addr    = maddr[d];
                e.data    = data;
                e.verde   = g;
                e.cyc     = ecyc;
                push_exp(d, e);
                maddr[d]++;
            end
        end else begin
            mbad[d] = 1'b1;
        end
        mx[d]++;
    endtask

    function automatic int next_byte();
        if (fbytes.size() > 0) return fbytes.pop_front();
        return int'($urandom_range(0, 255));
    endfunction

    task automatic send_line(input int groups, input int partial);
        int b[4];
        for (int g = 0; g < groups; g++) begin
            for (int k = 0; k < 4; k++) begin
                b[k] = next_byte();
                D    = DW'(b[k]);
                HREF = 1'b1;
                step();
            end
            for (int d = 0; d < 2; d++) begin
                model_pixel(d, b[0], b[1], b[3], cyc + 1);
                model_pixel(d, b[2], b[1], b[3], cyc + 2);
            end
        end
        for (int p = 0; p < partial; p++) begin
            D    = DW'($urandom_range(0, 255));
            HREF = 1'b1;
            step();
        end
        HREF = 1'b0;
        D    = '0;
        for (int d = 0; d < 2; d++) begin
            if (m_state[d] == 1) begin
                if (partial != 0) mbad[d] = 1'b1;
                if (mpix[d]) begin
                    if (mx[d] < hp[d]) mbad[d] = 1'b1;
                    my[d]++;
                end
                mx[d]   = 0;
                mpix[d] = 1'b0;
            end
        end
        repeat (6 + $urandom_range(0, 3)) step();
    endtask

    task automatic frame_start();
        VSYNC = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (m_state[d] == 0 && enable) begin
                m_state[d] = 1;
                mx[d] = 0; my[d] = 0; maddr[d] = 0;
                mbad[d] = 1'b0; mpix[d] = 1'b0;
            end
        end
        step();
        check_val("busy_a_frame", int'(busy_a), int'(m_state[0] == 1));
        check_val("busy_b_frame", int'(busy_b), int'(m_state[1] == 1));
        repeat (4) step();
    endtask

    task automatic run_frame(input int lines, input int groups, input int odd_line,
                             input int odd_groups, input int odd_partial);
        exp_t e;
        bit   good;
        frame_start();
        for (int l = 0; l < lines; l++) begin
            if (l == odd_line) send_line(odd_groups, odd_partial);
            else               send_line(groups, 0);
        end
        VSYNC = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            if (m_state[d] == 1) begin
                good      = (my[d] == vp[d]) && !mbad[d];
                e.is_stat = 1'b1;
                e.done    = good;
                e.addr    = 0;
                e.data    = 0;
                e.verde   = 1'b0;
                e.cyc     = cyc;
                push_exp(d, e);
                m_state[d] = (single_shot && good) ? 2 : 0;
                if (m_state[d] == 2 && !enable) m_state[d] = 0;
            end
        end
        repeat (6) step();
    endtask

    task automatic set_enable(input bit v);
        enable = v;
        if (!v) begin
            for (int d = 0; d < 2; d++) if (m_state[d] == 2) m_state[d] = 0;
        end
        repeat (3) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lines;
        reset = 1'b1; VSYNC = 1'b1; HREF = 1'b0; enable = 1'b0; single_shot = 1'b0;
        mode = 2'd0; D = '0; y_min = 8'd16; cb_max = 8'd100; cr_max = 8'd100;
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; mx[d] = 0; my[d] = 0; maddr[d] = 0; mbad[d] = 1'b0; mpix[d] = 1'b0;
        end
        repeat (3) step();
        check_val("reset_a", int'({wr_en_a, addr_a, data_a, verde_a, done_a, err_a, busy_a}), 0);
        check_val("reset_b", int'({wr_en_b, addr_b, data_b, verde_b, done_b, err_b, busy_b}), 0);
        reset = 1'b0;
        step();

        // Bytes without a VSYNC fall are ignored.
        enable = 1'b1;
        send_line(2, 0);
        check_val("idle_busy_a", int'(busy_a), 0);
        check_val("idle_busy_b", int'(busy_b), 0);

        // Directed luma frame: Y 10,20,30,40 on both lines.
        for (int r = 0; r < 2; r++) begin
            fbytes.push_back(10); fbytes.push_back(128); fbytes.push_back(20); fbytes.push_back(128);
            fbytes.push_back(30); fbytes.push_back(128); fbytes.push_back(40); fbytes.push_back(128);
        end
        run_frame(2, 2, -1, 0, 0);

        // Green mask on a known group.
        mode = 2'd1; y_min = 8'd16; cb_max = 8'd100; cr_max = 8'd100;
        fbytes.push_back(50); fbytes.push_back(90); fbytes.push_back(10); fbytes.push_back(90);
        run_frame(2, 2, -1, 0, 0);

        // Full 8x4 frame, then overlong lines.
        mode = 2'd0;
        run_frame(4, 4, -1, 0, 0);
        run_frame(4, 5, -1, 0, 0);

        // Single-shot hold and re-arm.
        single_shot = 1'b1;
        run_frame(2, 2, -1, 0, 0);
        run_frame(2, 2, -1, 0, 0);
        set_enable(1'b0);
        set_enable(1'b1);
        run_frame(2, 2, -1, 0, 0);
        single_shot = 1'b0;
        set_enable(1'b0);
        set_enable(1'b1);

        // Partial group at line end.
        mode = 2'd2;
        run_frame(2, 2, 1, 2, 2);

        // Reset in the middle of a frame: no status pulse follows.
        frame_start();
        send_line(1, 0);
        reset = 1'b1;
        step();
        for (int d = 0; d < 2; d++) m_state[d] = 0;
        check_val("midreset_busy_a", int'(busy_a), 0);
        check_val("midreset_busy_b", int'(busy_b), 0);
        reset = 1'b0;
        VSYNC = 1'b1;
        repeat (6) step();

        // Randomized frames.
        for (int f = 0; f < 10; f++) begin
            mode   = 2'($urandom_range(0, 3));
            y_min  = DW'($urandom_range(0, 128));
            cb_max = DW'($urandom_range(64, 255));
            cr_max = DW'($urandom_range(64, 255));
            lines  = int'($urandom_range(1, 5));
            run_frame(lines, int'($urandom_range(1, 5)), int'($urandom_range(0, 6)),
                      int'($urandom_range(1, 5)), int'($urandom_range(0, 3)));
        end

        repeat (10) step();
        check_val("leftover_a", q0.size(), 0);
        check_val("leftover_b", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
